saturn_bus_program_sequencer: RTL and testbench

SATURN_BUS_PROGRAM_SEQUENCER -- requirements
Module: saturn_bus_program_sequencer

---
 rtl/saturn_bus_program_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_saturn_bus_program_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_bus_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : saturn_bus_program_sequencer
// Purpose  : Turns bus operation requests from two requesters (A = control
//            unit, B = debugger) into nibble entries of a 32 x 6 program
//            buffer that the bus controller drains through its own read
//            pointer.
//            Every operation writes one command entry followed by either 5
//            address nibbles (LOAD_PC / LOAD_DP) or len+1 data entries
//            (DP_WRITE / DP_READ).
// Config   : SATURN_BUS_SEQ_RR_EN  - when defined, simultaneous requests are
//            arbitrated round-robin. Otherwise A has fixed priority.
// Ports    :
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_clk_en            advance enable (state frozen when low)
//   i_x_req/op/addr/len/data  request and its fields, x = a | b
//   o_a_ack, o_b_ack    one-cycle grant pulses
//   o_program_address   buffer write pointer
//   i_program_address   buffer read pointer (from the bus controller)
//   o_program_data      buffer entry at the read pointer {read, cmd, nibble}
//   o_busy              sequencer is working on an operation
// Revision : 1.0 - initial release
// ============================================================================
module saturn_bus_program_sequencer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic        i_a_req,
  input  logic [1:0]  i_a_op,
  input  logic [19:0] i_a_addr,
  input  logic [3:0]  i_a_len,
  input  logic [63:0] i_a_data,
  input  logic        i_b_req,
  input  logic [1:0]  i_b_op,
  input  logic [19:0] i_b_addr,
  input  logic [3:0]  i_b_len,
  input  logic [63:0] i_b_data,
  output logic        o_a_ack,
  output logic        o_b_ack,
  output logic [4:0]  o_program_address,
  input  logic [4:0]  i_program_address,
  output logic [5:0]  o_program_data,
  output logic        o_busy
);

  // Operation codes
  localparam logic [1:0] OP_LOAD_PC  = 2'd0;
  localparam logic [1:0] OP_LOAD_DP  = 2'd1;
  localparam logic [1:0] OP_DP_WRITE = 2'd2;
  localparam logic [1:0] OP_DP_READ  = 2'd3;

  // Command nibbles written in the first entry of each operation
  localparam logic [3:0] CMD_LOAD_PC  = 4'h6;
  localparam logic [3:0] CMD_LOAD_DP  = 4'h7;
  localparam logic [3:0] CMD_DP_WRITE = 4'h5;
  localparam logic [3:0] CMD_DP_READ  = 4'h3;

  // Index of the last of the five address nibbles
  localparam logic [3:0] ADDR_LAST = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic [1:0]  op_q;
  logic [19:0] addr_q;
  logic [3:0]  len_q;
  logic [63:0] data_q;
  logic [3:0]  cnt_q;
  logic [4:0]  wr_ptr_q;
  logic        a_ack_q;
  logic        b_ack_q;
  logic [5:0]  mem_q [32];

`ifdef SATURN_BUS_SEQ_RR_EN
  // 1 = B was granted last; reset value makes A win the first tie.
  logic        last_b_q;
`endif

  // --------------------------------------------------------------------------
  // Next-state helpers
  // --------------------------------------------------------------------------
  logic [4:0]  wr_ptr_d;
  logic [3:0]  cnt_d;

  assign wr_ptr_d = wr_ptr_q + 5'd1;   // natural 5-bit wrap 31 -> 0
  assign cnt_d    = cnt_q + 4'd1;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic        w_any_req;
  logic        w_grant_b;
  logic [1:0]  w_sel_op;
  logic [19:0] w_sel_addr;
  logic [3:0]  w_sel_len;
  logic [63:0] w_sel_data;

  assign w_any_req = i_a_req | i_b_req;

`ifdef SATURN_BUS_SEQ_RR_EN
  // On a tie, B wins only if A was the last one served.
  assign w_grant_b = i_b_req & (~i_a_req | ~last_b_q);
`else
  assign w_grant_b = i_b_req & ~i_a_req;
`endif

  assign w_sel_op   = w_grant_b ? i_b_op   : i_a_op;
  assign w_sel_addr = w_grant_b ? i_b_addr : i_a_addr;
  assign w_sel_len  = w_grant_b ? i_b_len  : i_a_len;
  assign w_sel_data = w_grant_b ? i_b_data : i_a_data;

  // --------------------------------------------------------------------------
  // Buffer occupancy and write-entry formation
  // --------------------------------------------------------------------------
  logic        w_full;
  logic        w_wr_en;
  logic        w_last;
  logic [3:0]  w_cmd_nib;
  logic [3:0]  w_addr_nib;
  logic [3:0]  w_data_nib;
  logic [5:0]  w_wr_data;

  // One slot is always left free so that equal pointers mean empty.
  assign w_full  = (wr_ptr_d == i_program_address);

  // Reset is folded in so that a reset cycle never disturbs buffer contents.
  assign w_wr_en = i_clk_en & ~i_reset & ~w_full & (state_q != ST_IDLE);

  assign w_addr_nib = addr_q[{cnt_q[2:0], 2'b00} +: 4];
  assign w_data_nib = data_q[{cnt_q, 2'b00} +: 4];

  always_comb begin
    w_cmd_nib = CMD_LOAD_PC;
    case (op_q)
      OP_LOAD_PC:  w_cmd_nib = CMD_LOAD_PC;
      OP_LOAD_DP:  w_cmd_nib = CMD_LOAD_DP;
      OP_DP_WRITE: w_cmd_nib = CMD_DP_WRITE;
      OP_DP_READ:  w_cmd_nib = CMD_DP_READ;
      default:     w_cmd_nib = CMD_LOAD_PC;
    endcase
  end

  always_comb begin
    w_wr_data = 6'b000000;
    w_last    = 1'b0;
    case (state_q)
      ST_CMD: begin
        w_wr_data = {2'b01, w_cmd_nib};
      end
      ST_ADDR: begin
        w_wr_data = {2'b00, w_addr_nib};
        w_last    = (cnt_q == ADDR_LAST);
      end
      ST_DATA: begin
        // Read slots carry no payload; the bus controller fills them in.
        w_wr_data = (op_q == OP_DP_READ) ? 6'b100000 : {2'b00, w_data_nib};
        w_last    = (cnt_q == len_q);
      end
      default: begin
        w_wr_data = 6'b000000;
        w_last    = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD_PC;
      addr_q   <= 20'd0;
      len_q    <= 4'd0;
      data_q   <= 64'd0;
      cnt_q    <= 4'd0;
      wr_ptr_q <= 5'd0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
`ifdef SATURN_BUS_SEQ_RR_EN
      last_b_q <= 1'b1;
`endif
    end else begin
      // Acks are cleared regardless of i_clk_en so a pulse never stretches.
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      if (i_clk_en) begin
        case (state_q)
          ST_IDLE: begin
            if (w_any_req) begin
              op_q     <= w_sel_op;
              addr_q   <= w_sel_addr;
              len_q    <= w_sel_len;
              data_q   <= w_sel_data;
              cnt_q    <= 4'd0;
              a_ack_q  <= ~w_grant_b;
              b_ack_q  <= w_grant_b;
              state_q  <= ST_CMD;
`ifdef SATURN_BUS_SEQ_RR_EN
              last_b_q <= w_grant_b;
`endif
            end
          end
          ST_CMD: begin
            if (w_wr_en) begin
              wr_ptr_q <= wr_ptr_d;
              cnt_q    <= 4'd0;
              // op[1] separates the DP transfers from the pointer loads.
              state_q  <= op_q[1] ? ST_DATA : ST_ADDR;
            end
          end
          ST_ADDR, ST_DATA: begin
            if (w_wr_en) begin
              wr_ptr_q <= wr_ptr_d;
              if (w_last) begin
                cnt_q   <= 4'd0;
                state_q <= ST_IDLE;
              end else begin
                cnt_q   <= cnt_d;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Program buffer: not reset, written one entry per enabled cycle
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= w_wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_program_data    = mem_q[i_program_address];
  assign o_program_address = wr_ptr_q;
  assign o_a_ack           = a_ack_q;
  assign o_b_ack           = b_ack_q;
  assign o_busy            = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_saturn_bus_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_saturn_bus_program_sequencer
// Purpose  : Scoreboard bench for saturn_bus_program_sequencer. Stimulus
//            pushes expected grants and buffer entries into queues; a
//            monitor thread consumes the buffer like the bus controller and
//            compares each entry and each ack pulse against the queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_saturn_bus_program_sequencer;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        a_req, b_req;
  logic [1:0]  a_op, b_op;
  logic [19:0] a_addr, b_addr;
  logic [3:0]  a_len, b_len;
  logic [63:0] a_data, b_data;
  logic        a_ack, b_ack;
  logic [4:0]  wr_ptr;
  logic [4:0]  rd_ptr;
  logic [5:0]  prog_data;
  logic        busy;

  logic [5:0]  exp_q[$];
  bit          grant_q[$];
  int          n_checks;
  int          n_errors;
  bit          consume_en;
  bit          last_b;

  saturn_bus_program_sequencer dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_clk_en          (clk_en),
    .i_a_req           (a_req),
    .i_a_op            (a_op),
    .i_a_addr          (a_addr),
    .i_a_len           (a_len),
    .i_a_data          (a_data),
    .i_b_req           (b_req),
    .i_b_op            (b_op),
    .i_b_addr          (b_addr),
    .i_b_len           (b_len),
    .i_b_data          (b_data),
    .o_a_ack           (a_ack),
    .o_b_ack           (b_ack),
    .o_program_address (wr_ptr),
    .i_program_address (rd_ptr),
    .o_program_data    (prog_data),
    .o_busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout or unexpected event", name);
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Expected grant plus up to n_max expected entries of one operation.
  task automatic push_model(input bit who_b, input logic [1:0] op, input logic [19:0] addr,
                            input logic [3:0] len, input logic [63:0] data, input int n_max);
    logic [5:0] ent[$];
    logic [3:0] cmd;
    case (op)
      2'd0:    cmd = 4'h6;
      2'd1:    cmd = 4'h7;
      2'd2:    cmd = 4'h5;
      default: cmd = 4'h3;
    endcase
    ent.push_back({2'b01, cmd});
    if (op < 2'd2) begin
      for (int i = 0; i < 5; i++) ent.push_back({2'b00, addr[4*i +: 4]});
    end else begin
      for (int i = 0; i <= int'(len); i++)
        ent.push_back((op == 2'd3) ? 6'b100000 : {2'b00, data[4*i +: 4]});
    end
    for (int i = 0; i < n_max && i < ent.size(); i++) exp_q.push_back(ent[i]);
    grant_q.push_back(who_b);
    last_b = who_b;
  endtask

  task automatic start_req(input bit who_b, input logic [1:0] op, input logic [19:0] addr,
                           input logic [3:0] len, input logic [63:0] data);
    if (who_b) begin
      b_req = 1'b1; b_op = op; b_addr = addr; b_len = len; b_data = data;
    end else begin
      a_req = 1'b1; a_op = op; a_addr = addr; a_len = len; a_data = data;
    end
  endtask

  task automatic wait_ack(input bit who_b);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (who_b ? b_ack : a_ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now(who_b ? "wait_ack_b" : "wait_ack_a");
  endtask

  task automatic drop_req(input bit who_b);
    if (who_b) b_req = 1'b0;
    else       a_req = 1'b0;
  endtask

  task automatic issue(input bit who_b, input logic [1:0] op, input logic [19:0] addr,
                       input logic [3:0] len, input logic [63:0] data);
    push_model(who_b, op, addr, len, data, 32);
    start_req(who_b, op, addr, len, data);
    wait_ack(who_b);
    drop_req(who_b);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) fail_now("wait_idle");
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) fail_now("wait_drain");
  endtask

  // Called only with the sequencer idle and the buffer drained.
  task automatic do_reset();
    reset = 1'b1;
    step();
    rd_ptr = 5'd0;
    reset  = 1'b0;
    last_b = 1'b1;
  endtask

  // A LOAD_PC and B DP_WRITE requested together and held until acked.
  task automatic both_req();
    bit first_b;
    bit a_seen = 1'b0;
    bit b_seen = 1'b0;
`ifdef SATURN_BUS_SEQ_RR_EN
    first_b = ~last_b;
`else
    first_b = 1'b0;
`endif
    if (first_b) begin
      push_model(1'b1, 2'd2, 20'd0, 4'd0, 64'h9, 32);
      push_model(1'b0, 2'd0, 20'h0F1E2, 4'd0, 64'd0, 32);
    end else begin
      push_model(1'b0, 2'd0, 20'h0F1E2, 4'd0, 64'd0, 32);
      push_model(1'b1, 2'd2, 20'd0, 4'd0, 64'h9, 32);
    end
    start_req(1'b0, 2'd0, 20'h0F1E2, 4'd0, 64'd0);
    start_req(1'b1, 2'd2, 20'd0, 4'd0, 64'h9);
    for (int k = 0; k < 300 && !(a_seen && b_seen); k++) begin
      step();
      if (a_ack) begin a_seen = 1'b1; a_req = 1'b0; end
      if (b_ack) begin b_seen = 1'b1; b_req = 1'b0; end
    end
    if (!(a_seen && b_seen)) fail_now("both_req_acks");
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // Ack checker and buffer consumer, sampling on the falling edge.
  task automatic monitor();
    bit prev_ack = 1'b0;
    bit g;
    forever begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        check("ack_onehot", 64'(a_ack & b_ack), 64'd0);
        check("ack_width", 64'(prev_ack), 64'd0);
        if (grant_q.size() == 0) fail_now("ack_unexpected");
        else begin
          g = grant_q.pop_front();
          check("grant_is_b", 64'(b_ack), 64'(g));
        end
      end
      prev_ack = a_ack | b_ack;
      if (consume_en && (wr_ptr != rd_ptr)) begin
        if (exp_q.size() == 0) fail_now("entry_unexpected");
        else check($sformatf("entry@%0d", rd_ptr), 64'(prog_data), 64'(exp_q.pop_front()));
        rd_ptr = rd_ptr + 5'd1;
      end
    end
  endtask

  initial begin
    logic [5:0] v030[6];
    logic [5:0] v031w[4];
    logic [5:0] v031r[3];
    logic [4:0] p;
    bit en;
    bit b;
    v030  = '{6'h16, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01};
    v031w = '{6'h15, 6'h0A, 6'h0B, 6'h0C};
    v031r = '{6'h13, 6'h20, 6'h20};
    n_checks = 0; n_errors = 0;
    consume_en = 1'b0; last_b = 1'b1;
    reset = 1'b1; clk_en = 1'b1; rd_ptr = 5'd0;
    a_req = 1'b0; a_op = 2'd0; a_addr = 20'd0; a_len = 4'd0; a_data = 64'd0;
    b_req = 1'b0; b_op = 2'd0; b_addr = 20'd0; b_len = 4'd0; b_data = 64'd0;
    fork
      monitor();
    join_none
    step();
    step();
    reset = 1'b0;
    consume_en = 1'b1;
    check("reset_ptr", 64'(wr_ptr), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_a_ack", 64'(a_ack), 64'd0);
    check("reset_b_ack", 64'(b_ack), 64'd0);

    // A LOAD_PC 12345
    grant_q.push_back(1'b0); last_b = 1'b0;
    foreach (v030[i]) exp_q.push_back(v030[i]);
    start_req(1'b0, 2'd0, 20'h12345, 4'd0, 64'd0);
    wait_ack(1'b0);
    drop_req(1'b0);
    step();
    check("a_ack_one_cycle", 64'(a_ack), 64'd0);
    wait_idle();
    wait_drain();
    check("loadpc_ptr", 64'(wr_ptr), 64'd6);
    check("loadpc_busy", 64'(busy), 64'd0);

    // B DP_WRITE len 2, then DP_READ len 1
    grant_q.push_back(1'b1); last_b = 1'b1;
    foreach (v031w[i]) exp_q.push_back(v031w[i]);
    start_req(1'b1, 2'd2, 20'd0, 4'd2, 64'hCBA);
    wait_ack(1'b1);
    drop_req(1'b1);
    wait_idle();
    grant_q.push_back(1'b1); last_b = 1'b1;
    foreach (v031r[i]) exp_q.push_back(v031r[i]);
    start_req(1'b1, 2'd3, 20'd0, 4'd1, 64'd0);
    wait_ack(1'b1);
    drop_req(1'b1);
    wait_idle();
    wait_drain();
    check("dp_ptr", 64'(wr_ptr), 64'd13);

    // A LOAD_DP
    issue(1'b0, 2'd1, 20'hABCDE, 4'd0, 64'd0);
    wait_idle();
    wait_drain();
    check("loaddp_ptr", 64'(wr_ptr), 64'd19);

    // Simultaneous requests, a single B in between, pointer wraps
    both_req();
    wait_idle();
    wait_drain();
    check("both1_ptr", 64'(wr_ptr), 64'd27);
    issue(1'b1, 2'd3, 20'd0, 4'd0, 64'd0);
    wait_idle();
    wait_drain();
    both_req();
    wait_idle();
    wait_drain();
    check("both2_wrap_ptr", 64'(wr_ptr), 64'd5);

    // Full buffer: read pointer parked at 0
    do_reset();
    check("reset2_ptr", 64'(wr_ptr), 64'd0);
    consume_en = 1'b0;
    issue(1'b0, 2'd2, 20'd0, 4'd15, 64'hFEDCBA9876543210);
    issue(1'b1, 2'd2, 20'd0, 4'd15, 64'h0123456789ABCDEF);
    for (int k = 0; k < 30; k++) step();
    check("full_ptr", 64'(wr_ptr), 64'd31);
    check("full_busy", 64'(busy), 64'd1);
    step(); step(); step();
    check("full_hold_ptr", 64'(wr_ptr), 64'd31);
    consume_en = 1'b1;
    wait_idle();
    wait_drain();
    check("full_resume_ptr", 64'(wr_ptr), 64'd2);

    // Reset in ADDR after two address nibbles, request held
    do_reset();
    push_model(1'b0, 2'd0, 20'h7A5C3, 4'd0, 64'd0, 3);
    start_req(1'b0, 2'd0, 20'h7A5C3, 4'd0, 64'd0);
    wait_ack(1'b0);
    step(); step(); step();
    check("pre_reset_ptr", 64'(wr_ptr), 64'd3);
    reset = 1'b1;
    step();
    rd_ptr = 5'd0;
    reset  = 1'b0;
    check("midreset_ptr", 64'(wr_ptr), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_a_ack", 64'(a_ack), 64'd0);
    last_b = 1'b1;
    push_model(1'b0, 2'd0, 20'h7A5C3, 4'd0, 64'd0, 32);
    wait_ack(1'b0);
    drop_req(1'b0);
    wait_idle();
    wait_drain();
    check("regrant_ptr", 64'(wr_ptr), 64'd6);

    // Clock enable toggling during DP_WRITE len 15
    push_model(1'b0, 2'd2, 20'd0, 4'd15, 64'h5A5A_C3C3_0F0F_1234, 32);
    start_req(1'b0, 2'd2, 20'd0, 4'd15, 64'h5A5A_C3C3_0F0F_1234);
    wait_ack(1'b0);
    drop_req(1'b0);
    for (int k = 0; k < 40; k++) begin
      en = (k % 2) == 1;
      p  = wr_ptr;
      b  = busy;
      clk_en = en;
      step();
      if (!en)    check("clken_hold", 64'(wr_ptr), 64'(p));
      else if (b) check("clken_adv", 64'(wr_ptr), 64'(5'(p + 5'd1)));
    end
    clk_en = 1'b1;
    wait_idle();
    wait_drain();
    check("clken_ptr", 64'(wr_ptr), 64'd23);

    step(); step();
    check("grant_q_empty", 64'(grant_q.size()), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
